// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. It grants at most one finished
// execution result per cycle and broadcasts the granted result one cycle later.
module cdb_arbiter #(
  parameter int N_REQ      = 3,
  parameter int ROB_ID_BIT = 4
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ROB_ID_BIT-1:0] req_rob_id,
  input  logic [N_REQ*32-1:0]         req_value,
  input  logic [N_REQ*32-1:0]         req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        cdb_valid,
  output logic [ROB_ID_BIT-1:0]       cdb_rob_id,
  output logic [31:0]                 cdb_value,
  output logic [31:0]                 cdb_addr,
  output logic [1:0]                  cdb_src
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]      r_prio;
  logic                  r_cdb_valid;
  logic [ROB_ID_BIT-1:0] r_cdb_rob_id;
  logic [31:0]           r_cdb_value;
  logic [31:0]           r_cdb_addr;
  logic [1:0]            r_cdb_src;

  logic                  w_grant_any;
  logic [IDX_W-1:0]      w_grant_idx;
  logic [IDX_W-1:0]      w_next_prio;
  logic [N_REQ-1:0]      w_onehot;
  logic                  w_fire;
  logic [ROB_ID_BIT-1:0] w_sel_id;
  logic [31:0]           w_sel_value;
  logic [31:0]           w_sel_addr;
  int                    w_scan;

  // Scan from the highest offset down so the first valid index after prio wins last.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan      = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan = int'(r_prio) + k;
      if (w_scan >= N_REQ) w_scan = w_scan - N_REQ;
      if (req_valid[w_scan[IDX_W-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_onehot    = '0;
    w_sel_id    = '0;
    w_sel_value = '0;
    w_sel_addr  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_onehot[i] = w_grant_any;
        w_sel_id    = req_rob_id[i*ROB_ID_BIT +: ROB_ID_BIT];
        w_sel_value = req_value[i*32 +: 32];
        w_sel_addr  = req_addr[i*32 +: 32];
      end
    end
  end

  assign w_fire      = !rst_in && rdy_in && !flush_in && w_grant_any;
  assign w_next_prio = (w_grant_idx == IDX_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
  assign req_ready   = w_fire ? w_onehot : '0;

  // Pause freezes everything, including a broadcast already on the bus.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_prio       <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_addr   <= '0;
      r_cdb_src    <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_prio      <= '0;
        r_cdb_valid <= 1'b0;
      end else if (w_grant_any) begin
        r_prio       <= w_next_prio;
        r_cdb_valid  <= 1'b1;
        r_cdb_rob_id <= w_sel_id;
        r_cdb_value  <= w_sel_value;
        r_cdb_addr   <= w_sel_addr;
        r_cdb_src    <= 2'(w_grant_idx);
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_rob_id = r_cdb_rob_id;
  assign cdb_value  = r_cdb_value;
  assign cdb_addr   = r_cdb_addr;
  assign cdb_src    = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: a driver feeds a round-robin reference model that
// queues expected broadcasts, and a monitor compares them with the CDB outputs.
module tb_cdb_arbiter;

  typedef struct {
    logic        v;
    logic        chkData;
    logic [3:0]  id;
    logic [31:0] val;
    logic [31:0] addr;
    logic [1:0]  src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [11:0] req_rob_id = '0;
  logic [95:0] req_value = '0;
  logic [95:0] req_addr = '0;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic [31:0] cdb_addr;
  logic [1:0]  cdb_src;

  logic [3:0]  reqId [3];
  logic [31:0] reqVal [3];
  logic [31:0] reqAddr [3];
  logic [2:0]  pending;

  exp_t expQ [$];
  exp_t lastExp;
  int   modelPrio = 0;
  int   checks = 0;
  int   failures = 0;
  bit   started = 1'b0;

  cdb_arbiter #(.N_REQ(3), .ROB_ID_BIT(4)) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .req_valid  (req_valid),
    .req_rob_id (req_rob_id),
    .req_value  (req_value),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_addr   (cdb_addr),
    .cdb_src    (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides the grant from the round-robin rule.
  task automatic applyStimulus(input logic r, input logic rdy, input logic fl, input logic [2:0] v,
                               input logic useDir, input logic [2:0] dirReady, output int g);
    exp_t e;
    logic [2:0] expReady;
    @(negedge clk);
    rst_in = r;
    rdy_in = rdy;
    flush_in = fl;
    req_valid = v;
    for (int i = 0; i < 3; i++) begin
      req_rob_id[i*4 +: 4] = reqId[i];
      req_value[i*32 +: 32] = reqVal[i];
      req_addr[i*32 +: 32] = reqAddr[i];
    end
    started = 1'b1;
    g = -1;
    e = '{v: 1'b0, chkData: 1'b0, id: '0, val: '0, addr: '0, src: '0};
    if (r) begin
      modelPrio = 0;
      e.chkData = 1'b1;
      expQ.push_back(e);
    end else if (!rdy) begin
      g = -1;
    end else if (fl) begin
      modelPrio = 0;
      expQ.push_back(e);
    end else begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (modelPrio + k) % 3;
        if (v[idx] && g < 0) g = idx;
      end
      if (g >= 0) begin
        e.v = 1'b1;
        e.id = reqId[g];
        e.val = reqVal[g];
        e.addr = reqAddr[g];
        e.src = 2'(g);
        modelPrio = (g + 1) % 3;
      end
      expQ.push_back(e);
    end
    expReady = (g >= 0) ? (3'b001 << g) : 3'b000;
    #1;
    checkOutput("req_ready", 64'(req_ready), 64'(expReady));
    if (useDir) checkOutput("req_ready_directed", 64'(req_ready), 64'(dirReady));
  endtask

  // Monitor: active edges consume one expected entry, paused edges must hold the bus.
  initial begin
    logic sr, sy, act;
    exp_t e;
    forever begin
      @(posedge clk);
      sr = rst_in;
      sy = rdy_in;
      act = started;
      #1;
      if (act) begin
        if (sr || sy) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL queue_underflow: got broadcast slot with no expected entry at %0t", $time);
          end else begin
            e = expQ.pop_front();
            lastExp = e;
            checkOutput("cdb_valid", 64'(cdb_valid), 64'(e.v));
            if (e.v || e.chkData) begin
              checkOutput("cdb_rob_id", 64'(cdb_rob_id), 64'(e.id));
              checkOutput("cdb_value", 64'(cdb_value), 64'(e.val));
              checkOutput("cdb_addr", 64'(cdb_addr), 64'(e.addr));
              checkOutput("cdb_src", 64'(cdb_src), 64'(e.src));
            end
          end
        end else begin
          checkOutput("hold_valid", 64'(cdb_valid), 64'(lastExp.v));
          if (lastExp.v) begin
            checkOutput("hold_rob_id", 64'(cdb_rob_id), 64'(lastExp.id));
            checkOutput("hold_value", 64'(cdb_value), 64'(lastExp.val));
            checkOutput("hold_src", 64'(cdb_src), 64'(lastExp.src));
          end
        end
      end
    end
  end

  initial begin
    int g;
    for (int i = 0; i < 3; i++) begin
      reqId[i] = 4'(i + 1);
      reqVal[i] = 32'h1000 + 32'(i);
      reqAddr[i] = 32'h8000 + 32'(i);
    end

    // Reset and single ALU result
    applyStimulus(1, 1, 0, 3'b111, 1, 3'b000, g);
    applyStimulus(1, 1, 0, 3'b000, 1, 3'b000, g);
    reqId[0] = 4'd5;
    reqVal[0] = 32'hDEAD_BEEF;
    reqAddr[0] = 32'h0000_0100;
    applyStimulus(0, 1, 0, 3'b001, 1, 3'b001, g);
    applyStimulus(0, 1, 0, 3'b000, 1, 3'b000, g);

    // All three requesting from prio 0
    applyStimulus(1, 1, 0, 3'b000, 1, 3'b000, g);
    for (int c = 0; c < 6; c++) begin
      logic [2:0] dr;
      dr = 3'b001 << (c % 3);
      for (int i = 0; i < 3; i++) reqId[i] = 4'(c * 3 + i + 1);
      applyStimulus(0, 1, 0, 3'b111, 1, dr, g);
    end

    // Wrap from prio 2 to index 0
    applyStimulus(0, 1, 0, 3'b010, 1, 3'b010, g);
    applyStimulus(0, 1, 0, 3'b011, 1, 3'b001, g);
    applyStimulus(0, 1, 0, 3'b010, 1, 3'b010, g);

    // Flush drops the pending result and clears prio
    applyStimulus(0, 1, 0, 3'b010, 1, 3'b010, g);
    applyStimulus(0, 1, 1, 3'b010, 1, 3'b000, g);
    applyStimulus(0, 1, 0, 3'b000, 1, 3'b000, g);
    applyStimulus(0, 1, 0, 3'b110, 1, 3'b010, g);

    // Pause holds the broadcast and prio
    reqVal[2] = 32'hCAFE_0002;
    applyStimulus(0, 1, 0, 3'b100, 1, 3'b100, g);
    for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 3'b011, 1, 3'b000, g);
    applyStimulus(0, 1, 0, 3'b011, 1, 3'b001, g);

    // Reset mid-operation
    applyStimulus(1, 1, 0, 3'b111, 1, 3'b000, g);
    applyStimulus(0, 1, 0, 3'b111, 1, 3'b001, g);

    // Randomized traffic with pauses, flushes and occasional resets
    pending = '0;
    for (int c = 0; c < 500; c++) begin
      logic r, rdy, fl;
      for (int i = 0; i < 3; i++) begin
        if (!pending[i] && ($urandom_range(2) == 0)) begin
          pending[i] = 1'b1;
          reqId[i] = 4'($urandom);
          reqVal[i] = $urandom;
          reqAddr[i] = $urandom;
        end
      end
      r = ($urandom_range(59) == 0);
      rdy = ($urandom_range(4) != 0);
      fl = ($urandom_range(19) == 0);
      applyStimulus(r, rdy, fl, pending, 0, 3'b000, g);
      if (g >= 0) pending[g] = 1'b0;
      if (r) pending = '0;
      else if (rdy && fl) begin
        for (int i = 0; i < 3; i++) if ($urandom_range(1) == 0) pending[i] = 1'b0;
      end
    end

    applyStimulus(0, 1, 0, 3'b000, 0, 3'b000, g);
    applyStimulus(0, 1, 0, 3'b000, 0, 3'b000, g);
    @(posedge clk);
    #2;
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
